spi_slave_sync: RTL and testbench
=================================

# spi_slave_sync

Parametrised, fully synchronous SPI slave that replaces the earlier SCK-clocked slave. All SPI pins are oversampled in the system clock domain, so a single clock drives every flop. The block supports all four CPOL/CPHA modes and multi-word frames under one SSN assertion. TX and RX each use a one-word buffer with a valid/ready handshake. It sits between the SPI pads and the register/DMA side of the peripheral.

## Interface
- DW, 8: word width in bits, ≥ 4.
- SYNC_STAGES, 2: synchroniser depth on sck/ssn/mosi, ≥ 2.

- clk  in  1  system clock.
- rst  in  1  reset; rst, synchronous, active-low; clock clk.
- cpol  in  1  idle SCK level. Quasi-static; change only while ssn is high.
- cpha  in  1  0: sample on the leading edge; 1: sample on the trailing edge. Quasi-static.
- tx_data  in  DW  word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  TX holding buffer is empty.
- rx_data  out  DW  last received word.
- rx_valid  out  1  rx_data is valid; held until accepted.
- rx_ready  in  1  consumer accepts rx_data.
- rx_overrun  out  1  sticky: a word completed while rx_valid was high.
- tx_underrun  out  1  sticky: a word started with the TX buffer empty.
- err_clr  in  1  single-cycle pulse; clears both sticky flags.
- busy  out  1  FSM is in ACTIVE.
- sck, ssn (active-low), mosi  in  1  raw pads, asynchronous to clk.
- miso  out  1  serial data out.
- miso_oe  out  1  output enable for the pad tristate.
- lsb_first  in  1  present only with SPI_SLV_LSB_FIRST_EN.

## Operation
- sck, ssn and mosi each pass through SYNC_STAGES flops. Edges of sck are detected from the last two synchronised samples.
- Leading edge is the transition away from cpol. Sample edge is the leading edge when cpha=0, the trailing edge when cpha=1. Shift edge is the other one.
- FSM states:
  - IDLE → ARMED when synchronised ssn is seen high.
  - ARMED → ACTIVE on the ssn falling edge.
  - ACTIVE → ARMED on ssn rising.
  - Any state → IDLE on reset.
- A frame that is already low when reset releases is ignored until ssn goes high and falls again.
- Word start (entry to ACTIVE, or bit_cnt wrap): the shift register loads the TX buffer and the buffer is freed. If the buffer is empty, the shift register loads all zeros and tx_underrun is set.
- cpha=0: miso presents bit DW-1 at word start.
- cpha=1: miso presents bit DW-1 on the first shift edge.
- Each sample edge shifts mosi in and increments bit_cnt (0..DW-1).
- On the sample edge at bit_cnt=DW-1:
  - If rx_valid=0: rx_data takes the assembled word and rx_valid is set.
  - Else: the new word is dropped, rx_data is kept, and rx_overrun is set.
  - bit_cnt wraps to 0 and the next word starts.
- Each shift edge, other than one coinciding with a word start, drives the next bit on miso.
- ssn rising mid-word: partial RX bits are discarded, no rx_valid is raised, the TX word in the shift register is lost, and bit_cnt is cleared.
- TX handshake: the buffer loads when tx_valid && tx_ready. If a word start and a load occur in the same cycle, the word start takes the old buffer contents first; the new word then fills the freed buffer.
- RX handshake: rx_valid clears on rx_valid && rx_ready. If a new word completes in the same cycle as acceptance, it is stored and rx_valid stays high with no overrun.
- err_clr clears both sticky flags. If a set and a clear coincide, the set wins.
- miso_oe = ACTIVE state. miso is 0 whenever miso_oe=0.

## Timing
- Reset values: rx_data=0, rx_valid=0, rx_overrun=0, tx_underrun=0, tx_ready=1, busy=0, miso=0, miso_oe=0, bit_cnt=0, FSM=IDLE.
- Constraints on the SPI master:
  - SCK high and low phases each ≥ SYNC_STAGES+2 clk periods.
  - ssn-fall to first SCK edge ≥ SYNC_STAGES+2 clk periods.
- ssn edge at pin → busy/miso_oe change: SYNC_STAGES+1 clk.
- Shift edge at pin → miso update: SYNC_STAGES+1 clk.
- Last sample edge at pin → rx_valid high: SYNC_STAGES+2 clk.
- Handshake outputs (tx_ready, rx_valid) update one clk after the accepting edge.

## Configuration
- SPI_SLV_LSB_FIRST_EN defined: the lsb_first port exists. When lsb_first=1, TX shifts out bit 0 first and RX assembles the first received bit into bit 0. Sample quasi-static, like cpol/cpha.
- Not defined: the port is absent and all transfers are MSB first.

## Test plan
- Mode 0, DW=8: tx 0xA5 preloaded, master sends 0x3C → miso stream 1,0,1,0,0,1,0,1; rx_data=0x3C; rx_valid held until rx_ready.
- All four modes: master sends 0x81, slave sends 0x7E → both sides are correct in every mode; no underrun.
- Two-word frame with rx_ready tied low: second word 0x55 completes → rx_data stays at the first word and rx_overrun=1; err_clr → 0.
- Frame started with the TX buffer empty → miso all 0 and tx_underrun=1; tx_ready=1 throughout.
- ssn released after 5 bits → no rx_valid, busy=0; the next full frame 0xC3 is received correctly.
- With SPI_SLV_LSB_FIRST_EN and lsb_first=1: tx 0x01 → first miso bit is 1; master sends MSB-first bits of 0x80 → rx_data=0x01.

Source files
------------

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI slave, all pins oversampled on clk, CPOL/CPHA modes,
// multi-word frames, one-word TX/RX buffers with valid/ready handshakes.
// Ports: clk, rst (sync, active-low), cpol, cpha, tx_data/tx_valid/tx_ready,
//   rx_data/rx_valid/rx_ready, rx_overrun, tx_underrun, err_clr, busy,
//   sck, ssn, mosi (raw pads), miso, miso_oe.
// Optional: SPI_SLV_LSB_FIRST_EN adds the lsb_first input.
module spi_slave_sync #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpol,
  input  logic          cpha,
`ifdef SPI_SLV_LSB_FIRST_EN
  input  logic          lsb_first,
`endif
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic          rx_overrun,
  output logic          tx_underrun,
  input  logic          err_clr,
  output logic          busy,
  input  logic          sck,
  input  logic          ssn,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oe
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW-1);

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sck_sr;
  logic [SYNC_STAGES-1:0] ssn_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic sck_s, ssn_s, mosi_s;
  logic sck_d, ssn_d;

  logic [CW-1:0] bit_cnt;
  logic [DW-1:0] rx_sr;
  logic [DW-1:0] tx_sr;
  logic [DW-1:0] tx_buf;
  logic          tx_full;
  logic          done;

  logic lsb;
  logic lead, trail;
  logic act, samp_e, shift_e;
  logic ssn_fall, start, load;
  logic [DW-1:0] tx_word;
  logic [DW-1:0] rx_next;
  logic [CW-1:0] tx_idx;

`ifdef SPI_SLV_LSB_FIRST_EN
  assign lsb = lsb_first;
`else
  assign lsb = 1'b0;
`endif

  assign sck_s  = sck_sr[SYNC_STAGES-1];
  assign ssn_s  = ssn_sr[SYNC_STAGES-1];
  assign mosi_s = mosi_sr[SYNC_STAGES-1];

  assign lead  = (sck_d == cpol) && (sck_s != cpol);
  assign trail = (sck_d != cpol) && (sck_s == cpol);

  // SCK edges only count while the frame is still selected
  assign act     = (state == ACTIVE) && !ssn_s;
  assign samp_e  = act && (cpha ? trail : lead);
  assign shift_e = act && (cpha ? lead : trail);

  assign ssn_fall = ssn_d && !ssn_s;
  assign start    = ((state == ARMED) && ssn_fall) ||
                    (samp_e && (bit_cnt == LAST));
  assign load     = tx_valid && tx_ready;
  assign tx_word  = tx_full ? tx_buf : '0;

  assign rx_next = lsb ? {mosi_s, rx_sr[DW-1:1]}
                       : {rx_sr[DW-2:0], mosi_s};

  // next bit is indexed by the bit count of the upcoming sample
  assign tx_idx = lsb ? bit_cnt : LAST - bit_cnt;

  assign tx_ready = !tx_full;
  assign busy     = (state == ACTIVE);
  assign miso_oe  = (state == ACTIVE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      // ssn resets low so a frame already in progress is ignored
      sck_sr      <= '0;
      ssn_sr      <= '0;
      mosi_sr     <= '0;
      sck_d       <= 1'b0;
      ssn_d       <= 1'b0;
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      done        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      miso        <= 1'b0;
    end else begin
      sck_sr  <= {sck_sr[SYNC_STAGES-2:0], sck};
      ssn_sr  <= {ssn_sr[SYNC_STAGES-2:0], ssn};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      sck_d   <= sck_s;
      ssn_d   <= ssn_s;
      done    <= 1'b0;

      unique case (state)
        IDLE:   if (ssn_s) state <= ARMED;
        ARMED:  if (ssn_fall) state <= ACTIVE;
        ACTIVE: if (ssn_s) begin
          state   <= ARMED;
          bit_cnt <= '0;
          miso    <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (samp_e) begin
        rx_sr <= rx_next;
        if (bit_cnt == LAST) begin
          bit_cnt <= '0;
          done    <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      if (shift_e) miso <= tx_sr[tx_idx];

      if (start) begin
        tx_sr <= tx_word;
        if (!cpha) miso <= lsb ? tx_word[0] : tx_word[DW-1];
      end

      // start consumes the old buffer before a same-cycle load
      if (load) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end else if (start) begin
        tx_full <= 1'b0;
      end

      // rx_sr is complete the cycle after the last sample edge
      if (done && (!rx_valid || rx_ready)) begin
        rx_data  <= rx_sr;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      rx_overrun  <= (rx_overrun && !err_clr) ||
                     (done && rx_valid && !rx_ready);
      tx_underrun <= (tx_underrun && !err_clr) ||
                     (start && !tx_full);
    end
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: directed bench for spi_slave_sync with a bit-level
// SPI master driving the pads from clk negedges.
module tb_spi_slave_sync;

  localparam int H = 6;

  logic       clk;
  logic       rst;
  logic       cpol, cpha;
`ifdef SPI_SLV_LSB_FIRST_EN
  logic       lsb_first;
`endif
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       rx_overrun, tx_underrun, err_clr, busy;
  logic       sck, ssn, mosi, miso, miso_oe;

  int checks = 0;
  int errors = 0;

  spi_slave_sync #(.DW(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha),
`ifdef SPI_SLV_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun),
    .err_clr(err_clr), .busy(busy),
    .sck(sck), .ssn(ssn), .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol = p;
    cpha = h;
    sck  = p;
    wait_clk(H);
  endtask

  task automatic push(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;
  endtask

  task automatic ssn_low();
    ssn = 1'b0;
    wait_clk(H);
  endtask

  task automatic ssn_high();
    wait_clk(H);
    ssn = 1'b1;
    wait_clk(H);
  endtask

  task automatic spi_bit(input logic b, output logic r);
    if (!cpha) begin
      mosi = b;
      wait_clk(H);
      sck = ~cpol;
      r   = miso;
      wait_clk(H);
      sck = cpol;
    end else begin
      sck  = ~cpol;
      mosi = b;
      wait_clk(H);
      sck = cpol;
      r   = miso;
      wait_clk(H);
    end
  endtask

  task automatic spi_word(input logic [7:0] mo, output logic [7:0] mi);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(mo[i], r);
      mi[i] = r;
    end
  endtask

  logic [7:0] mi, mi2;
  logic       rb;

  initial begin
    rst = 1'b0; cpol = 1'b0; cpha = 1'b0;
`ifdef SPI_SLV_LSB_FIRST_EN
    lsb_first = 1'b0;
`endif
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
    sck = 1'b0; ssn = 1'b1; mosi = 1'b0;
    wait_clk(5);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_overrun", rx_overrun, 0);
    check("rst_underrun", tx_underrun, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    rst = 1'b1;
    wait_clk(H);

    // mode 0 basic transfer
    set_mode(1'b0, 1'b0);
    push(8'hA5);
    check("m0_tx_full", tx_ready, 0);
    ssn_low();
    check("m0_busy", busy, 1);
    check("m0_oe", miso_oe, 1);
    check("m0_first_bit", miso, 1);
    check("m0_tx_freed", tx_ready, 1);
    push(8'h00);
    spi_word(8'h3C, mi);
    ssn_high();
    check("m0_miso_word", mi, 8'hA5);
    check("m0_rx_data", rx_data, 8'h3C);
    check("m0_busy_off", busy, 0);
    check("m0_miso_idle", miso, 0);
    wait_clk(10);
    check("m0_rx_hold", rx_valid, 1);
    accept();
    check("m0_rx_acc", rx_valid, 0);
    check("m0_no_under", tx_underrun, 0);

    // all four modes
    for (int m = 0; m < 4; m++) begin
      set_mode(m[1], m[0]);
      push(8'h7E);
      ssn_low();
      push(8'hFF);
      spi_word(8'h81, mi);
      ssn_high();
      check($sformatf("mode%0d_miso", m), mi, 8'h7E);
      check($sformatf("mode%0d_rx", m), rx_data, 8'h81);
      check($sformatf("mode%0d_rxv", m), rx_valid, 1);
      check($sformatf("mode%0d_under", m), tx_underrun, 0);
      accept();
    end

    // two-word frame, consumer stalled
    set_mode(1'b0, 1'b0);
    push(8'h11);
    ssn_low();
    push(8'h22);
    spi_word(8'hA0, mi);
    push(8'h33);
    spi_word(8'h55, mi2);
    ssn_high();
    check("ovr_miso0", mi, 8'h11);
    check("ovr_miso1", mi2, 8'h22);
    check("ovr_rx_kept", rx_data, 8'hA0);
    check("ovr_rxv", rx_valid, 1);
    check("ovr_flag", rx_overrun, 1);
    check("ovr_no_under", tx_underrun, 0);
    clear_err();
    check("ovr_clr", rx_overrun, 0);
    accept();

    // frame with empty TX buffer
    check("und_ready_pre", tx_ready, 1);
    ssn_low();
    check("und_flag", tx_underrun, 1);
    check("und_ready", tx_ready, 1);
    spi_word(8'h0F, mi);
    check("und_ready_end", tx_ready, 1);
    ssn_high();
    check("und_miso", mi, 8'h00);
    check("und_rx", rx_data, 8'h0F);
    accept();
    clear_err();
    check("und_clr", tx_underrun, 0);

    // aborted frame then full frame
    push(8'h99);
    ssn_low();
    for (int i = 0; i < 5; i++) spi_bit(1'b1, rb);
    ssn_high();
    check("abort_rxv", rx_valid, 0);
    check("abort_busy", busy, 0);
    push(8'h5A);
    ssn_low();
    push(8'h00);
    spi_word(8'hC3, mi);
    ssn_high();
    check("after_abort_rx", rx_data, 8'hC3);
    check("after_abort_rxv", rx_valid, 1);
    check("after_abort_miso", mi, 8'h5A);
    accept();

`ifdef SPI_SLV_LSB_FIRST_EN
    lsb_first = 1'b1;
    wait_clk(2);
    push(8'h01);
    ssn_low();
    check("lsb_first_bit", miso, 1);
    push(8'h00);
    spi_word(8'h80, mi);
    ssn_high();
    check("lsb_miso", mi, 8'h80);
    check("lsb_rx", rx_data, 8'h01);
    accept();
    lsb_first = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
